mdu_ctrl: RTL and testbench
===========================

Name: mdu_ctrl

Overview:
- Multi-cycle multiply/divide sequencer in the E stage of the 5-stage MIPS pipeline.
- Owns the HI/LO registers and the busy counter.
- Produces the D-stage stall request for HI/LO-dependent instructions.
- Services mthi/mtlo/mfhi/mflo and suppresses new operations when an exception/interrupt flush (req) is active.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (must be >= 1).
- DIV_CYCLES, 10, busy cycles for div/divu (must be >= 1).

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  E-stage instruction is mult/multu/div/divu
- md_op  in  2  00 mult, 01 multu, 10 div, 11 divu; sampled when start=1
- a  in  32  rs operand (forwarded)
- b  in  32  rt operand (forwarded)
- hilo_we  in  1  E-stage mthi/mtlo
- hilo_sel  in  1  0 = HI, 1 = LO; target of hilo_we
- re_hilo  in  2  01 read HI, 10 read LO, else read 0
- req  in  1  exception/interrupt flush this cycle; blocks new start and hilo_we
- d_md_use  in  1  D-stage instruction is mult/div/mthi/mtlo/mfhi/mflo (stall_busy)
- busy  out  1  operation in progress
- stall  out  1  D-stage stall request
- hilo_rdata  out  32  HI/LO read data to the E-stage result mux

Behaviour:
- Reset: state IDLE, cnt=0, HI=0, LO=0, pending result=0, busy=0. Asynchronous reset mid-operation aborts it with HI/LO=0.
- States: IDLE, RUN.
- Start acceptance: start & ~req & IDLE at edge T:
  - Latch pending_hi/pending_lo.
  - Load cnt = MULT_CYCLES for md_op[1]=0, or DIV_CYCLES for md_op[1]=1.
  - Go to RUN.
- Operand arithmetic:
  - mult: signed 32x32 -> 64; HI = [63:32], LO = [31:0].
  - multu: the same, unsigned.
  - div: LO = quotient truncated toward zero, HI = remainder with the sign of the dividend.
  - divu: unsigned quotient and remainder.
- Divide by zero (b=0 on div/divu): the operation runs its full DIV_CYCLES; HI/LO are left unchanged at completion.
- RUN:
  - busy=1; cnt decrements each edge.
  - On the edge where cnt==1: HI/LO take the pending values, state returns to IDLE.
  - busy is high for exactly N cycles after the start edge; new HI/LO are readable in cycle T+N+1.
- start while RUN: ignored. The stall makes this unreachable; the bench flags it as an error.
- start & req: ignored; stays IDLE, HI/LO untouched.
- hilo_we & ~req:
  - Writes a into HI (hilo_sel=0) or LO (hilo_sel=1) at the edge.
  - Accepted only in IDLE; ignored in RUN (unreachable under stall).
  - Does not affect the other register.
- req while RUN: the operation continues to completion, since it was already committed.
- Stall: stall = d_md_use & (busy | start), combinational. It must be high in the cycle start is presented, so the following HI/LO user never reads stale data.
- hilo_rdata: combinational from the current HI/LO registers.
  - Not forwarded from pending values.
  - Not forwarded from a same-cycle hilo_we; the stall covers this case.
- Output widths: all 32-bit arithmetic; the 64-bit product is computed internally.

Test Plan:
- Multiply path: mult a=0xFFFFFFFE (-2), b=3, start 1 cycle -> busy high 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA; multu with the same operands -> HI=0x00000002, LO=0xFFFFFFFA.
- Divide path: div a=0xFFFFFFF9 (-7), b=2 -> busy 10 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu a=7, b=0 -> busy 10 cycles; then HI/LO unchanged from the prior values.
- Stall sequencing: start mult with d_md_use=1 (mflo in D) -> stall=1 in the start cycle and all 5 busy cycles, 0 in the following cycle; hilo_rdata with re_hilo=10 then equals the new LO.
- req suppression: req=1 together with start (or with hilo_we, a=0x12345678) -> busy stays 0, HI/LO unchanged; req=1 during RUN -> the result is still written at completion.
- mthi/mtlo writes: hilo_we, sel=0, a=0xAAAA0000, then sel=1, a=0x0000BBBB -> re_hilo=01 reads 0xAAAA0000, 10 reads 0x0000BBBB, 00 reads 0.
- Async reset: reset asserted low in busy cycle 3 of a div -> busy=0 and HI=LO=0 immediately; after release, a new mult completes normally.

Source files
------------

// File: rtl/mdu_ctrl.sv
// Multiply/divide sequencer for the E stage: owns HI/LO, runs MULT_CYCLES/DIV_CYCLES busy window,
// commits the pending result on the final busy edge; D-stage stall asserted while busy or on start.
module mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_start,
    input  logic [1:0]  i_md_op,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic        i_hilo_we,
    input  logic        i_hilo_sel,
    input  logic [1:0]  i_re_hilo,
    input  logic        i_req,
    input  logic        i_d_md_use,
    output logic        o_busy,
    output logic        o_stall,
    output logic [31:0] o_hilo_rdata
);
    localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

    state_t             r_state, w_state_nxt;
    logic [CW-1:0]      r_cnt, w_cnt_nxt;
    logic [31:0]        r_hi, r_lo, r_pend_hi, r_pend_lo;
    logic               r_pend_we;
    logic               w_accept, w_commit, w_hilo_wr, w_div0;
    logic [63:0]        w_prod_s, w_prod_u;
    logic signed [31:0] w_a_s, w_b_s, w_quo_s, w_rem_s;
    logic [31:0]        w_quo_u, w_rem_u, w_res_hi, w_res_lo;

    assign w_a_s    = i_a;
    assign w_b_s    = i_b;
    assign w_div0   = (i_b == 32'd0);
    assign w_prod_s = $signed({{32{i_a[31]}}, i_a}) * $signed({{32{i_b[31]}}, i_b});
    assign w_prod_u = {32'd0, i_a} * {32'd0, i_b};

    // Divider is gated on b != 0 so a zero divisor never reaches the operators.
    always_comb begin
        w_quo_s = '0;
        w_rem_s = '0;
        w_quo_u = '0;
        w_rem_u = '0;
        if (!w_div0) begin
            w_quo_s = w_a_s / w_b_s;
            w_rem_s = w_a_s % w_b_s;
            w_quo_u = i_a / i_b;
            w_rem_u = i_a % i_b;
        end
    end

    always_comb begin
        w_res_hi = w_prod_s[63:32];
        w_res_lo = w_prod_s[31:0];
        case (i_md_op)
            2'b01: begin
                w_res_hi = w_prod_u[63:32];
                w_res_lo = w_prod_u[31:0];
            end
            2'b10: begin
                w_res_hi = w_rem_s;
                w_res_lo = w_quo_s;
            end
            2'b11: begin
                w_res_hi = w_rem_u;
                w_res_lo = w_quo_u;
            end
            default: ;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        w_commit    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start && !i_req) begin
                    w_accept    = 1'b1;
                    w_cnt_nxt   = i_md_op[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                w_cnt_nxt = r_cnt - 1'b1;
                if (r_cnt == CW'(1)) begin
                    w_commit    = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign w_hilo_wr = i_hilo_we && !i_req && (r_state == S_IDLE);

    // A zero-divisor divide still occupies the unit but leaves HI/LO intact.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_hi      <= '0;
            r_lo      <= '0;
            r_pend_hi <= '0;
            r_pend_lo <= '0;
            r_pend_we <= 1'b0;
        end else begin
            if (w_accept) begin
                r_pend_hi <= w_res_hi;
                r_pend_lo <= w_res_lo;
                r_pend_we <= !(i_md_op[1] && w_div0);
            end
            if (w_commit && r_pend_we) begin
                r_hi <= r_pend_hi;
                r_lo <= r_pend_lo;
            end else if (w_hilo_wr) begin
                if (i_hilo_sel) r_lo <= i_a;
                else            r_hi <= i_a;
            end
        end
    end

    assign o_busy  = (r_state == S_RUN);
    assign o_stall = i_d_md_use && (o_busy || i_start);

    always_comb begin
        case (i_re_hilo)
            2'b01:   o_hilo_rdata = r_hi;
            2'b10:   o_hilo_rdata = r_lo;
            default: o_hilo_rdata = '0;
        endcase
    end
endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl: arithmetic results, busy window, stall, req gating, async reset.
module tb_mdu_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_start, i_hilo_we, i_hilo_sel, i_req, i_d_md_use;
    logic [1:0]  i_md_op, i_re_hilo;
    logic [31:0] i_a, i_b;
    logic        o_busy, o_stall;
    logic [31:0] o_hilo_rdata;
    int          checks = 0;
    int          errors = 0;

    mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .i_clk(clk), .i_reset(rst_n), .i_start(i_start), .i_md_op(i_md_op),
        .i_a(i_a), .i_b(i_b), .i_hilo_we(i_hilo_we), .i_hilo_sel(i_hilo_sel),
        .i_re_hilo(i_re_hilo), .i_req(i_req), .i_d_md_use(i_d_md_use),
        .o_busy(o_busy), .o_stall(o_stall), .o_hilo_rdata(o_hilo_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [1:0] sel, input string tag, input logic [31:0] exp);
        i_re_hilo = sel;
        #1;
        chk(tag, o_hilo_rdata, exp);
    endtask

    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int n, input logic use_d, input int req_at, input string tag);
        i_md_op    = op;
        i_a        = a;
        i_b        = b;
        i_d_md_use = use_d;
        i_start    = 1'b1;
        #2;
        chk({tag, "_busy_at_start"}, {31'd0, o_busy}, 32'd0);
        if (use_d) chk({tag, "_stall_start"}, {31'd0, o_stall}, 32'd1);
        cyc();
        i_start = 1'b0;
        i_a     = 32'd0;
        i_b     = 32'd0;
        for (int i = 0; i < n; i++) begin
            i_req = (i == req_at);
            #2;
            chk($sformatf("%s_busy_c%0d", tag, i), {31'd0, o_busy}, 32'd1);
            if (use_d) chk($sformatf("%s_stall_c%0d", tag, i), {31'd0, o_stall}, 32'd1);
            cyc();
        end
        i_req = 1'b0;
        #2;
        chk({tag, "_busy_done"}, {31'd0, o_busy}, 32'd0);
        if (use_d) chk({tag, "_stall_done"}, {31'd0, o_stall}, 32'd0);
        i_d_md_use = 1'b0;
        cyc();
    endtask

    initial begin
        rst_n      = 1'b0;
        i_start    = 1'b0;
        i_md_op    = 2'b00;
        i_a        = 32'd0;
        i_b        = 32'd0;
        i_hilo_we  = 1'b0;
        i_hilo_sel = 1'b0;
        i_re_hilo  = 2'b00;
        i_req      = 1'b0;
        i_d_md_use = 1'b1;
        cyc();
        #1;
        chk("rst_busy", {31'd0, o_busy}, 32'd0);
        chk("rst_stall", {31'd0, o_stall}, 32'd0);
        rd(2'b01, "rst_hi", 32'd0);
        rd(2'b10, "rst_lo", 32'd0);
        cyc();
        rst_n      = 1'b1;
        i_d_md_use = 1'b0;
        cyc();

        // mult -2 * 3 with mflo waiting in D
        do_op(2'b00, 32'hFFFF_FFFE, 32'd3, 5, 1'b1, -1, "mult");
        rd(2'b01, "mult_hi", 32'hFFFF_FFFF);
        rd(2'b10, "mult_lo", 32'hFFFF_FFFA);
        cyc();

        do_op(2'b01, 32'hFFFF_FFFE, 32'd3, 5, 1'b0, -1, "multu");
        rd(2'b01, "multu_hi", 32'h0000_0002);
        rd(2'b10, "multu_lo", 32'hFFFF_FFFA);
        cyc();

        do_op(2'b10, 32'hFFFF_FFF9, 32'd2, 10, 1'b0, -1, "div");
        rd(2'b01, "div_hi", 32'hFFFF_FFFF);
        rd(2'b10, "div_lo", 32'hFFFF_FFFD);
        cyc();

        do_op(2'b11, 32'd7, 32'd0, 10, 1'b0, -1, "divu0");
        rd(2'b01, "divu0_hi", 32'hFFFF_FFFF);
        rd(2'b10, "divu0_lo", 32'hFFFF_FFFD);
        cyc();

        // mthi / mtlo
        i_hilo_we  = 1'b1;
        i_hilo_sel = 1'b0;
        i_a        = 32'hAAAA_0000;
        cyc();
        i_hilo_sel = 1'b1;
        i_a        = 32'h0000_BBBB;
        cyc();
        i_hilo_we  = 1'b0;
        i_a        = 32'd0;
        rd(2'b01, "mthi_hi", 32'hAAAA_0000);
        rd(2'b10, "mtlo_lo", 32'h0000_BBBB);
        rd(2'b00, "re00_zero", 32'd0);
        cyc();
        rd(2'b11, "re11_zero", 32'd0);
        cyc();

        // req blocks start
        i_start = 1'b1;
        i_req   = 1'b1;
        i_md_op = 2'b00;
        i_a     = 32'd5;
        i_b     = 32'd5;
        cyc();
        i_start = 1'b0;
        i_req   = 1'b0;
        #1;
        chk("req_start_busy", {31'd0, o_busy}, 32'd0);
        cyc();
        chk("req_start_busy2", {31'd0, o_busy}, 32'd0);
        rd(2'b01, "req_start_hi", 32'hAAAA_0000);
        rd(2'b10, "req_start_lo", 32'h0000_BBBB);
        cyc();

        // req blocks mthi/mtlo
        i_hilo_we  = 1'b1;
        i_hilo_sel = 1'b0;
        i_req      = 1'b1;
        i_a        = 32'h1234_5678;
        cyc();
        i_hilo_sel = 1'b1;
        cyc();
        i_hilo_we = 1'b0;
        i_req     = 1'b0;
        i_a       = 32'd0;
        rd(2'b01, "req_we_hi", 32'hAAAA_0000);
        rd(2'b10, "req_we_lo", 32'h0000_BBBB);
        cyc();

        // req during RUN still commits
        do_op(2'b01, 32'h0001_0000, 32'h0001_0000, 5, 1'b0, 2, "run_req");
        rd(2'b01, "run_req_hi", 32'h0000_0001);
        rd(2'b10, "run_req_lo", 32'h0000_0000);
        cyc();

        // async reset during busy cycle 3 of a div
        i_start = 1'b1;
        i_md_op = 2'b10;
        i_a     = 32'd100;
        i_b     = 32'd7;
        cyc();
        i_start = 1'b0;
        cyc();
        cyc();
        #2;
        chk("pre_rst_busy", {31'd0, o_busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_busy", {31'd0, o_busy}, 32'd0);
        rd(2'b01, "arst_hi", 32'd0);
        rd(2'b10, "arst_lo", 32'd0);
        cyc();
        rst_n = 1'b1;
        cyc();
        chk("post_rst_busy", {31'd0, o_busy}, 32'd0);
        cyc();

        do_op(2'b00, 32'd7, 32'd6, 5, 1'b1, -1, "post_mult");
        rd(2'b01, "post_mult_hi", 32'd0);
        rd(2'b10, "post_mult_lo", 32'd42);
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
